alu_bus_master: RTL
===================

ALU_BUS_MASTER -- requirements
Module: alu_bus_master

Interface
REQ-001 Parameter POLL_LIMIT, 8'd255: max status-poll reads with done bit clear before timeout.
REQ-002 Parameter RAM_BASE, 8'h20: bus address of RAM word 0.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 job_valid  input  1  job request present.
REQ-006 job_ready  output  1  block can accept a job this cycle.
REQ-007 job_op2  input  32  operand2 value for ALU register 0x01.
REQ-008 job_shift  input  32  shift/control value for ALU register 0x02.
REQ-009 job_idx  input  5  RAM word index for result store.
REQ-010 done_valid  output  1  one-cycle job-complete pulse.
REQ-011 done_err  output  1  timeout flag, valid with done_valid.
REQ-012 done_result  output  32  result1 read back, valid with done_valid.
REQ-013 M_req  output  1  bus request.
REQ-014 M_wr  output  1  1 = write, 0 = read.
REQ-015 M_addr  output  8  bus address.
REQ-016 M_dout  output  32  write data to slave.
REQ-017 M_grant  input  1  slave accepts current beat.
REQ-018 M_din  input  32  read data from slave.

Function
REQ-019 Beat completes on the rising edge where M_req=1 and M_grant=1; M_wr/M_addr/M_dout SHALL stay stable from M_req rise until completion.
REQ-020 Read data SHALL be sampled from M_din on the completing edge of a read beat.
REQ-021 States: IDLE, WR_OP2, WR_SHIFT, WR_START, POLL, RD_RES, WR_RAM, DONE.
REQ-022 job_ready SHALL be 1 only in IDLE; job accepted on edge with job_valid&job_ready, latching job_op2, job_shift, job_idx; IDLE->WR_OP2.
REQ-023 WR_OP2: write addr 0x01, data op2; on completion ->WR_SHIFT.
REQ-024 WR_SHIFT: write addr 0x02, data shift; ->WR_START.
REQ-025 WR_START: write addr 0x05, data 32'h0000_0001; ->POLL, poll counter cleared.
REQ-026 POLL: read addr 0x04; completed read with M_din[0]=1 ->RD_RES; with M_din[0]=0 increments counter, and if counter reaches POLL_LIMIT ->DONE with err=1, result 0.
REQ-027 RD_RES: read addr 0x03; captured data stored as result; ->WR_RAM.
REQ-028 WR_RAM: write addr RAM_BASE + {3'b0, idx} (0x20..0x3F, no wrap beyond 0x3F), data = result; ->DONE.
REQ-029 DONE: done_valid=1 for exactly one cycle with done_result/done_err; ->IDLE; done_result/done_err hold until next DONE.
REQ-030 In IDLE and DONE, M_req=0, M_wr=0, M_addr=0, M_dout=0.
REQ-031 Between consecutive beats M_req MAY stay high; next beat's address/data SHALL be presented the cycle after completion.
REQ-032 M_grant with M_req=0 SHALL be ignored.
REQ-033 job_valid outside IDLE SHALL be ignored (not queued).
REQ-034 Minimum job latency with M_grant tied 1 and first poll done: 6 bus beats, done_valid 7 cycles after acceptance edge.

Reset
REQ-035 reset=1 at an edge SHALL force IDLE, job_ready=1, done_valid=0, done_err=0, done_result=0, poll counter 0, all bus outputs 0, regardless of state.
REQ-036 Reset mid-beat SHALL drop M_req on the next edge with no further beats; the interrupted job is discarded with no done pulse.

Verification
REQ-037 Grant tied 1, op2=32'hffff_0000, shift=32'h0000_000a, idx=0, status reads 1, result read 32'h1234_5678 -> beats 01,02,05,04,03,20 in order; RAM write data 32'h1234_5678; done_valid pulse, done_err=0.
REQ-038 Grant low for 3 cycles on WR_SHIFT -> addr 0x02/data held stable all 3 cycles; sequence otherwise unchanged.
REQ-039 Status M_din[0]=0 for 4 polls then 1 -> exactly 5 reads of 0x04, then 0x03 read, done_err=0.
REQ-040 POLL_LIMIT=3, status always 0 -> 3 reads of 0x04, no 0x03/RAM beat, done_valid with done_err=1, done_result=0.
REQ-041 idx=5'h1f -> RAM write address 0x3F.
REQ-042 reset asserted during POLL -> next cycle M_req=0, job_ready=1, no done_valid; new job then runs normally.

Source files
------------

// File: rtl/alu_bus_master.sv
// -----------------------------------------------------------------------------
// alu_bus_master
//
// Runs one ALU job at a time over a simple request/grant register bus:
//   1. write operand2       -> ALU reg 0x01
//   2. write shift/control  -> ALU reg 0x02
//   3. write start (1)      -> ALU reg 0x05
//   4. poll status          <- ALU reg 0x04 until bit0 = 1 (bounded by POLL_LIMIT)
//   5. read result1         <- ALU reg 0x03
//   6. write result         -> RAM word idx at RAM_BASE + idx
// and then reports completion with a one-cycle done pulse.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   job_valid/job_ready        job handshake (ready only while idle)
//   job_op2, job_shift, job_idx job payload, latched on acceptance
//   done_valid                 one-cycle completion pulse
//   done_err, done_result      completion status, held until the next job ends
//   M_req, M_wr, M_addr, M_dout bus request and beat attributes
//   M_grant                    slave accepts the current beat
//   M_din                      read data, sampled on the completing edge
//
// A beat completes on a rising edge with M_req & M_grant. The bus outputs are
// decoded from registered state only, so they cannot change while a beat is
// waiting for its grant.
// -----------------------------------------------------------------------------
module alu_bus_master #(
    parameter logic [7:0] POLL_LIMIT = 8'd255,
    parameter logic [7:0] RAM_BASE   = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_op2,
    input  logic [31:0] job_shift,
    input  logic [4:0]  job_idx,
    output logic        done_valid,
    output logic        done_err,
    output logic [31:0] done_result,
    output logic        M_req,
    output logic        M_wr,
    output logic [7:0]  M_addr,
    output logic [31:0] M_dout,
    input  logic        M_grant,
    input  logic [31:0] M_din
);

    localparam logic [7:0] ADDR_OP2    = 8'h01;
    localparam logic [7:0] ADDR_SHIFT  = 8'h02;
    localparam logic [7:0] ADDR_RESULT = 8'h03;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_START  = 8'h05;

    typedef enum logic [2:0] {
        IDLE,
        WR_OP2,
        WR_SHIFT,
        WR_START,
        POLL,
        RD_RES,
        WR_RAM,
        DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] op2_reg, op2_next;
    logic [31:0] shift_reg, shift_next;
    logic [4:0]  idx_reg, idx_next;
    logic [31:0] result_reg, result_next;
    logic [7:0]  poll_cnt_reg, poll_cnt_next;
    logic [31:0] done_result_reg, done_result_next;
    logic        done_err_reg, done_err_next;
    logic        beat_done;

    assign done_err    = done_err_reg;
    assign done_result = done_result_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            op2_reg         <= '0;
            shift_reg       <= '0;
            idx_reg         <= '0;
            result_reg      <= '0;
            poll_cnt_reg    <= '0;
            done_result_reg <= '0;
            done_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            op2_reg         <= op2_next;
            shift_reg       <= shift_next;
            idx_reg         <= idx_next;
            result_reg      <= result_next;
            poll_cnt_reg    <= poll_cnt_next;
            done_result_reg <= done_result_next;
            done_err_reg    <= done_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        op2_next         = op2_reg;
        shift_next       = shift_reg;
        idx_next         = idx_reg;
        result_next      = result_reg;
        poll_cnt_next    = poll_cnt_reg;
        done_result_next = done_result_reg;
        done_err_next    = done_err_reg;
        job_ready        = 1'b0;
        done_valid       = 1'b0;
        M_req            = 1'b0;
        M_wr             = 1'b0;
        M_addr           = 8'h00;
        M_dout           = 32'h0;

        // Bus beat presented in each state.
        case (state_reg)
            IDLE:     job_ready = 1'b1;
            WR_OP2:   begin M_req = 1'b1; M_wr = 1'b1; M_addr = ADDR_OP2;   M_dout = op2_reg;   end
            WR_SHIFT: begin M_req = 1'b1; M_wr = 1'b1; M_addr = ADDR_SHIFT; M_dout = shift_reg; end
            WR_START: begin M_req = 1'b1; M_wr = 1'b1; M_addr = ADDR_START; M_dout = 32'h0000_0001; end
            POLL:     begin M_req = 1'b1; M_addr = ADDR_STATUS; end
            RD_RES:   begin M_req = 1'b1; M_addr = ADDR_RESULT; end
            WR_RAM:   begin
                M_req  = 1'b1;
                M_wr   = 1'b1;
                // idx is 5 bits, so the address stays inside the 32-word window.
                M_addr = RAM_BASE + {3'b000, idx_reg};
                M_dout = result_reg;
            end
            DONE:     done_valid = 1'b1;
            default:  ;
        endcase

        // A grant while nothing is requested never advances the sequence.
        beat_done = M_req && M_grant;

        case (state_reg)
            IDLE: begin
                if (job_valid) begin
                    op2_next   = job_op2;
                    shift_next = job_shift;
                    idx_next   = job_idx;
                    state_next = WR_OP2;
                end
            end
            WR_OP2:   if (beat_done) state_next = WR_SHIFT;
            WR_SHIFT: if (beat_done) state_next = WR_START;
            WR_START: begin
                if (beat_done) begin
                    poll_cnt_next = 8'd0;
                    state_next    = POLL;
                end
            end
            POLL: begin
                if (beat_done) begin
                    if (M_din[0]) begin
                        state_next = RD_RES;
                    end else begin
                        poll_cnt_next = poll_cnt_reg + 8'd1;
                        // Give up once POLL_LIMIT not-done reads have been seen.
                        if (poll_cnt_reg + 8'd1 == POLL_LIMIT) begin
                            done_err_next    = 1'b1;
                            done_result_next = 32'h0;
                            state_next       = DONE;
                        end
                    end
                end
            end
            RD_RES: begin
                if (beat_done) begin
                    result_next = M_din;
                    state_next  = WR_RAM;
                end
            end
            WR_RAM: begin
                if (beat_done) begin
                    done_err_next    = 1'b0;
                    done_result_next = result_reg;
                    state_next       = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule
